// File: rtl/controller_pkg.sv
// Shared types and constants for the bus pattern detector.
package controller_pkg;

  typedef enum logic [2:0] {
    Idle,
    AwaitScl,
    AwaitSr,
    AwaitP,
    Done
  } bus_pattern_state_e;

  typedef enum logic [1:0] {
    RstActNone,
    RstActPeriph,
    RstActTarget
  } rstact_e;

  localparam logic [7:0] RSTACT_NONE   = 8'h00;
  localparam logic [7:0] RSTACT_PERIPH = 8'h01;
  localparam logic [7:0] RSTACT_TARGET = 8'h02;

endpackage

// File: rtl/bus_pattern_detector_if.sv
// Event-strobe and reset-request bundle between the bus monitor and the pattern detector.
interface bus_pattern_detector_if;

  logic       enable_i;
  logic       scl_low_i;
  logic       scl_high_i;
  logic       scl_posedge_i;
  logic       scl_negedge_i;
  logic       sda_low_i;
  logic       sda_posedge_i;
  logic       sda_negedge_i;
  logic       start_detected_i;
  logic       stop_detected_i;
  logic       hdr_mode_i;
  logic       rstact_valid_i;
  logic [7:0] rstact_i;
  logic       getstatus_i;
  logic       tgt_rst_detect_o;
  logic       periph_rst_o;
  logic       target_rst_o;
  logic       escalate_armed_o;
  logic       hdr_exit_detect_o;

  modport master (
    output enable_i, scl_low_i, scl_high_i, scl_posedge_i, scl_negedge_i,
           sda_low_i, sda_posedge_i, sda_negedge_i, start_detected_i,
           stop_detected_i, hdr_mode_i, rstact_valid_i, rstact_i, getstatus_i,
    input  tgt_rst_detect_o, periph_rst_o, target_rst_o, escalate_armed_o,
           hdr_exit_detect_o
  );

  modport slave (
    input  enable_i, scl_low_i, scl_high_i, scl_posedge_i, scl_negedge_i,
           sda_low_i, sda_posedge_i, sda_negedge_i, start_detected_i,
           stop_detected_i, hdr_mode_i, rstact_valid_i, rstact_i, getstatus_i,
    output tgt_rst_detect_o, periph_rst_o, target_rst_o, escalate_armed_o,
           hdr_exit_detect_o
  );

endinterface

// File: rtl/sda_edge_counter.sv
// Saturating SDA edge counter; clear has priority over increment.
module sda_edge_counter #(
  parameter int unsigned Max          = 14,
  parameter bit          CountPosedge = 1'b1,
  localparam int unsigned CntW        = $clog2(Max + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic            sda_negedge_i,
  input  logic            sda_posedge_i,
  output logic [CntW-1:0] count_o
);

  logic [CntW-1:0] r_count;
  logic            w_inc;

  // A rising edge only counts once a falling edge has opened the sequence
  always_comb begin
    w_inc = en_i && (r_count < CntW'(Max)) &&
            (sda_negedge_i || (CountPosedge && sda_posedge_i && (r_count != '0)));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (clr_i) begin
      r_count <= '0;
    end else if (w_inc) begin
      r_count <= r_count + CntW'(1);
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/bus_pattern_detector.sv
// I3C Target Reset Pattern detector with RSTACT action and escalation.
// Define I3C_HDR_EXIT_DETECT_EN to add HDR Exit Pattern detection.
module bus_pattern_detector
  import controller_pkg::*;
#(
  parameter int unsigned TgtRstTransitions = 14,
  parameter int unsigned HdrExitFallEdges  = 4
) (
  input logic             clk_i,
  input logic             rst_i,
  bus_pattern_detector_if.slave bus
);

  localparam int unsigned CntW = $clog2(TgtRstTransitions + 1);

  bus_pattern_state_e r_state, w_state_d;
  rstact_e            r_action, w_action_d;
  logic               r_escalate, w_escalate_d;
  logic [CntW-1:0]    w_pat_cnt;
  logic               w_pat_full;
  logic               w_pulse;
  logic               w_done_d;
  logic               r_tgt_rst_detect, r_periph_rst, r_target_rst;

  sda_edge_counter #(
    .Max          (TgtRstTransitions),
    .CountPosedge (1'b1)
  ) u_pat_cnt (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clr_i         (bus.scl_high_i || !bus.enable_i || bus.hdr_mode_i),
    .en_i          (r_state == Idle),
    .sda_negedge_i (bus.sda_negedge_i),
    .sda_posedge_i (bus.sda_posedge_i),
    .count_o       (w_pat_cnt)
  );

  assign w_pat_full = (w_pat_cnt == CntW'(TgtRstTransitions));

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= Idle;
    else       r_state <= w_state_d;
  end

  // Abort conditions are tested before advance in every waiting state
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      Idle:     if (w_pat_full) w_state_d = AwaitScl;
      AwaitScl: if (bus.scl_high_i || bus.sda_low_i)         w_state_d = Idle;
                else if (bus.scl_posedge_i)                  w_state_d = AwaitSr;
      AwaitSr:  if (bus.scl_low_i || bus.sda_posedge_i)      w_state_d = Idle;
                else if (bus.start_detected_i)               w_state_d = AwaitP;
      AwaitP:   if (bus.scl_low_i || bus.sda_negedge_i)      w_state_d = Idle;
                else if (bus.stop_detected_i)                w_state_d = Done;
      Done:     w_state_d = Idle;
      default:  w_state_d = Idle;
    endcase
    if (!bus.enable_i) w_state_d = Idle;
  end

  // Done consumes the current action/flag; RSTACT or GETSTATUS take effect next cycle
  always_comb begin
    w_pulse      = (r_state == Done) && (r_escalate || (r_action != RstActNone));
    w_action_d   = r_action;
    w_escalate_d = r_escalate;
    if (r_state == Done) w_action_d = RstActPeriph;
    if (bus.rstact_valid_i) begin
      case (bus.rstact_i)
        RSTACT_NONE:   w_action_d = RstActNone;
        RSTACT_PERIPH: w_action_d = RstActPeriph;
        RSTACT_TARGET: w_action_d = RstActTarget;
        default:       w_action_d = r_action;
      endcase
    end
    if (bus.getstatus_i || bus.rstact_valid_i) w_escalate_d = 1'b0;
    else if (w_pulse)                          w_escalate_d = 1'b1;
    w_done_d = (w_state_d == Done);
  end

  // Pulses are registered from the next state so they coincide with Done
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_action         <= RstActPeriph;
      r_escalate       <= 1'b0;
      r_tgt_rst_detect <= 1'b0;
      r_periph_rst     <= 1'b0;
      r_target_rst     <= 1'b0;
    end else begin
      r_action         <= w_action_d;
      r_escalate       <= w_escalate_d;
      r_tgt_rst_detect <= w_done_d;
      r_periph_rst     <= w_done_d && !w_escalate_d && (w_action_d == RstActPeriph);
      r_target_rst     <= w_done_d && (w_escalate_d || (w_action_d == RstActTarget));
    end
  end

  assign bus.tgt_rst_detect_o = r_tgt_rst_detect;
  assign bus.periph_rst_o     = r_periph_rst;
  assign bus.target_rst_o     = r_target_rst;
  assign bus.escalate_armed_o = r_escalate;

`ifdef I3C_HDR_EXIT_DETECT_EN
  localparam int unsigned HdrW = $clog2(HdrExitFallEdges + 1);

  logic [HdrW-1:0] w_hdr_cnt;
  logic            w_hdr_full;
  logic            r_hdr_full_q;
  logic            r_hdr_exit;

  sda_edge_counter #(
    .Max          (HdrExitFallEdges),
    .CountPosedge (1'b0)
  ) u_hdr_cnt (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clr_i         (bus.scl_high_i || !bus.enable_i),
    .en_i          (bus.scl_low_i && bus.hdr_mode_i),
    .sda_negedge_i (bus.sda_negedge_i),
    .sda_posedge_i (1'b0),
    .count_o       (w_hdr_cnt)
  );

  assign w_hdr_full = (w_hdr_cnt == HdrW'(HdrExitFallEdges));

  // Single pulse on the first cycle the counter sits at its limit
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hdr_full_q <= 1'b0;
      r_hdr_exit   <= 1'b0;
    end else begin
      r_hdr_full_q <= w_hdr_full;
      r_hdr_exit   <= w_hdr_full && !r_hdr_full_q && bus.enable_i;
    end
  end

  assign bus.hdr_exit_detect_o = r_hdr_exit;
`else
  assign bus.hdr_exit_detect_o = 1'b0;
`endif

endmodule

// File: tb/tb_bus_pattern_detector.sv
// Directed bench for bus_pattern_detector; honours I3C_HDR_EXIT_DETECT_EN.
module tb_bus_pattern_detector;

  logic clk_i = 1'b0;
  logic rst_i;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk_i = ~clk_i;

  bus_pattern_detector_if bus ();

  bus_pattern_detector dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr_strobes();
    bus.scl_posedge_i    = 1'b0;
    bus.scl_negedge_i    = 1'b0;
    bus.sda_posedge_i    = 1'b0;
    bus.sda_negedge_i    = 1'b0;
    bus.start_detected_i = 1'b0;
    bus.stop_detected_i  = 1'b0;
    bus.rstact_valid_i   = 1'b0;
    bus.getstatus_i      = 1'b0;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic det, input logic per, input logic tgt);
    check({tag, ".detect"}, bus.tgt_rst_detect_o, det);
    check({tag, ".periph"}, bus.periph_rst_o, per);
    check({tag, ".target"}, bus.target_rst_o, tgt);
  endtask

  // SCL low, n SDA toggles (first falling), SCL rise, Sr, P; returns in the cycle after P
  task automatic do_pattern(input int n_edges, input bit abort_sr);
    bus.scl_high_i = 1'b0; bus.scl_low_i = 1'b1; bus.scl_negedge_i = 1'b1;
    cyc(); clr_strobes();
    for (int i = 0; i < n_edges; i++) begin
      if (i % 2 == 0) begin bus.sda_negedge_i = 1'b1; bus.sda_low_i = 1'b1; end
      else            begin bus.sda_posedge_i = 1'b1; bus.sda_low_i = 1'b0; end
      cyc(); clr_strobes();
    end
    cyc();
    bus.scl_posedge_i = 1'b1; bus.scl_low_i = 1'b0;
    cyc(); clr_strobes();
    bus.scl_high_i = 1'b1;
    if (abort_sr) begin
      bus.sda_posedge_i = 1'b1; bus.sda_low_i = 1'b0;
      cyc(); clr_strobes();
    end
    bus.sda_negedge_i = 1'b1; bus.sda_low_i = 1'b1; bus.start_detected_i = 1'b1;
    cyc(); clr_strobes();
    bus.sda_posedge_i = 1'b1; bus.sda_low_i = 1'b0; bus.stop_detected_i = 1'b1;
    cyc(); clr_strobes();
  endtask

  task automatic send_rstact(input logic [7:0] val);
    bus.rstact_valid_i = 1'b1; bus.rstact_i = val;
    cyc(); clr_strobes();
  endtask

  initial begin
    clr_strobes();
    bus.enable_i = 1'b1; bus.scl_high_i = 1'b1; bus.scl_low_i = 1'b0;
    bus.sda_low_i = 1'b0; bus.hdr_mode_i = 1'b0; bus.rstact_i = 8'h00;
    rst_i = 1'b1;
    cyc(); cyc();
    check_out("reset", 1'b0, 1'b0, 1'b0);
    check("reset.armed", bus.escalate_armed_o, 1'b0);
    check("reset.hdr", bus.hdr_exit_detect_o, 1'b0);
    rst_i = 1'b0;
    cyc();

    // Default action: peripheral reset, then escalation armed
    do_pattern(14, 1'b0);
    check_out("p1", 1'b1, 1'b1, 1'b0);
    cyc();
    check_out("p1.after", 1'b0, 1'b0, 1'b0);
    check("p1.armed", bus.escalate_armed_o, 1'b1);

    do_pattern(14, 1'b0);
    check_out("p2.escalated", 1'b1, 1'b0, 1'b1);
    cyc();
    check("p2.armed", bus.escalate_armed_o, 1'b1);

    bus.getstatus_i = 1'b1;
    cyc(); clr_strobes();
    check("getstatus.armed", bus.escalate_armed_o, 1'b0);

    do_pattern(14, 1'b0);
    check_out("p3", 1'b1, 1'b1, 1'b0);
    cyc();
    check("p3.armed", bus.escalate_armed_o, 1'b1);

    send_rstact(8'h00);
    check("rstact0.armed", bus.escalate_armed_o, 1'b0);
    do_pattern(14, 1'b0);
    check_out("p4.none", 1'b1, 1'b0, 1'b0);
    cyc();
    check("p4.armed", bus.escalate_armed_o, 1'b0);

    send_rstact(8'h02);
    do_pattern(14, 1'b0);
    check_out("p5.target", 1'b1, 1'b0, 1'b1);
    cyc();
    check("p5.armed", bus.escalate_armed_o, 1'b1);

    // GETSTATUS in the Done cycle: pulse uses the old flag, flag ends cleared
    do_pattern(14, 1'b0);
    bus.getstatus_i = 1'b1;
    check_out("p6.oldflag", 1'b1, 1'b0, 1'b1);
    cyc(); clr_strobes();
    check("p6.armed", bus.escalate_armed_o, 1'b0);
    check_out("p6.after", 1'b0, 1'b0, 1'b0);

    send_rstact(8'h05);
    do_pattern(14, 1'b0);
    check_out("p7.ignored_rstact", 1'b1, 1'b1, 1'b0);
    cyc();
    check("p7.armed", bus.escalate_armed_o, 1'b1);

    do_pattern(13, 1'b0);
    check_out("short13", 1'b0, 1'b0, 1'b0);
    cyc();
    check_out("short13.after", 1'b0, 1'b0, 1'b0);

    do_pattern(14, 1'b1);
    check_out("abort_sr", 1'b0, 1'b0, 1'b0);
    cyc();
    check_out("abort_sr.after", 1'b0, 1'b0, 1'b0);

    do_pattern(14, 1'b0);
    check_out("p8.recover", 1'b1, 1'b0, 1'b1);
    cyc();
    check("p8.armed", bus.escalate_armed_o, 1'b1);

    bus.enable_i = 1'b0;
    do_pattern(14, 1'b0);
    check_out("disabled", 1'b0, 1'b0, 1'b0);
    cyc();
    check("disabled.armed_held", bus.escalate_armed_o, 1'b1);
    bus.enable_i = 1'b1;

    bus.hdr_mode_i = 1'b1;
    do_pattern(14, 1'b0);
    check_out("hdr.blocked", 1'b0, 1'b0, 1'b0);
    cyc();

    // HDR exit: four SDA falls with SCL low
    bus.scl_high_i = 1'b0; bus.scl_low_i = 1'b1; bus.scl_negedge_i = 1'b1;
    cyc(); clr_strobes();
    for (int i = 0; i < 4; i++) begin
      bus.sda_negedge_i = 1'b1;
      cyc(); clr_strobes();
      if (i < 3) cyc();
    end
    check("hdr_exit.early", bus.hdr_exit_detect_o, 1'b0);
    cyc();
`ifdef I3C_HDR_EXIT_DETECT_EN
    check("hdr_exit.pulse", bus.hdr_exit_detect_o, 1'b1);
`else
    check("hdr_exit.tied", bus.hdr_exit_detect_o, 1'b0);
`endif
    cyc();
    check("hdr_exit.single", bus.hdr_exit_detect_o, 1'b0);
    check("hdr_exit.no_tgt", bus.tgt_rst_detect_o, 1'b0);

    bus.hdr_mode_i = 1'b0; bus.scl_low_i = 1'b0; bus.scl_high_i = 1'b1;
    cyc();
    do_pattern(14, 1'b0);
    check_out("p9.after_hdr", 1'b1, 1'b0, 1'b1);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
